// File: rtl/board_input_conditioner.sv
// board_input_conditioner: board button conditioning and console reset generation
//   clk           pixel clock, single domain
//   rst_n         asynchronous active-low reset
//   btn_n_raw     raw reset button, active-low, asynchronous
//   btn_raw       raw BTN1..BTN3, active-high, asynchronous
//   ui_out        console control vector packed from debounced buttons
//   game_rst_n    registered active-low console reset (power-on delay or long press)
//   led_heartbeat toggles every HOLD_CYCLES cycles
module board_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 25200000,
    parameter int POR_CYCLES      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n_raw,
    input  logic [2:0] btn_raw,
    output logic [7:0] ui_out,
    output logic       game_rst_n,
    output logic       led_heartbeat
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int PW = $clog2(POR_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HB_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] POR_MAX  = PW'(POR_CYCLES);
    // bit 0 is the active-low reset button, so its idle level is 1
    localparam logic [3:0] IDLE = 4'b0001;

    logic [3:0]          s1_q, s2_q, stable_q, stable_d;
    logic [3:0][DW-1:0]  db_q, db_d;
    logic [HW-1:0]       hold_q, hold_d, hb_q, hb_d;
    logic [PW-1:0]       por_q, por_d;
    logic                grst_q, grst_d, led_q, led_d;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_d[i]     = (s2_q[i] != stable_q[i] && db_q[i] != DB_LAST) ? db_q[i] + 1'b1 : '0;
            stable_d[i] = (s2_q[i] != stable_q[i] && db_q[i] == DB_LAST) ? s2_q[i] : stable_q[i];
        end
        hold_d = stable_q[0] ? '0 : (hold_q == HOLD_MAX ? hold_q : hold_q + 1'b1);
        por_d  = por_q == POR_MAX ? por_q : por_q + 1'b1;
        grst_d = (por_q == POR_MAX) && (hold_q != HOLD_MAX);
        hb_d   = hb_q == HB_LAST ? '0 : hb_q + 1'b1;
        led_d  = led_q ^ (hb_q == HB_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= IDLE;
            s2_q     <= IDLE;
            stable_q <= IDLE;
            db_q     <= '0;
            hold_q   <= '0;
            por_q    <= '0;
            grst_q   <= 1'b0;
            hb_q     <= '0;
            led_q    <= 1'b0;
        end else begin
            s1_q     <= {btn_raw, btn_n_raw};
            s2_q     <= s1_q;
            stable_q <= stable_d;
            db_q     <= db_d;
            hold_q   <= hold_d;
            por_q    <= por_d;
            grst_q   <= grst_d;
            hb_q     <= hb_d;
            led_q    <= led_d;
        end
    end

    // BTN2 drives both UP and LEFT, BTN3 both DOWN and RIGHT
    assign ui_out        = {1'b0, stable_q[3], stable_q[2], stable_q[3], stable_q[2], 1'b0, stable_q[1], stable_q[0]};
    assign game_rst_n    = grst_q;
    assign led_heartbeat = led_q;
endmodule
